// File: rtl/nerv_gdb_pkg.sv
// Shared types and constants for the NERV GDB run-control block.
package nerv_gdb_pkg;

    typedef enum logic [1:0] {
        CMD_HALT  = 2'd0,
        CMD_CONT  = 2'd1,
        CMD_STEP  = 2'd2,
        CMD_RESET = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2,
        ST_RESET  = 2'd3
    } state_t;

    localparam logic [7:0] SIG_TRAP = 8'd5;
    localparam logic [7:0] SIG_INT  = 8'd2;

    // Index width for n entries; a single entry still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nerv_gdb_bkpt.sv
// Hardware breakpoint bank: NBKPT word-address slots compared against the
// retiring next-PC, reporting a hit and the lowest matching slot index.
module nerv_gdb_bkpt
    import nerv_gdb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NBKPT = 4,
    localparam int IW   = idx_width(NBKPT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bp_we,
    input  logic [IW-1:0]   bp_idx,
    input  logic            bp_en,
    input  logic [XLEN-1:0] bp_addr,
    input  logic            ret_vld,
    input  logic [XLEN-1:0] ret_pc_nxt,
    output logic            hit,
    output logic [IW-1:0]   idx
);

    logic [NBKPT-1:0] en_r;
    logic [XLEN-1:2]  addr_r [NBKPT];
    logic [NBKPT-1:0] match_s;
    logic             unused_s;

    // Byte offset within the instruction word never takes part in the compare.
    assign unused_s = ^{bp_addr[1:0], ret_pc_nxt[1:0]};

    // Slot write port; a slot index beyond the bank matches no slot and is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_r <= '0;
            for (int i = 0; i < NBKPT; i++) begin
                addr_r[i] <= '0;
            end
        end else if (bp_we) begin
            for (int i = 0; i < NBKPT; i++) begin
                if (bp_idx == IW'(i)) begin
                    en_r[i]   <= bp_en;
                    addr_r[i] <= bp_addr[XLEN-1:2];
                end
            end
        end
    end

    // Per-slot word-address equality against the retiring next-PC.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NBKPT; i++) begin
            match_s[i] = ret_vld & en_r[i] & (addr_r[i] == ret_pc_nxt[XLEN-1:2]);
        end
    end

    // Lowest-index priority: scanning downward lets the smallest match land last.
    always_comb begin
        hit = |match_s;
        idx = '0;
        for (int i = NBKPT - 1; i >= 0; i--) begin
            idx = match_s[i] ? IW'(i) : idx;
        end
    end

endmodule

// File: rtl/nerv_gdb_runctl.sv
// Debug run-control: turns GDB stub commands into core stall/reset, watches
// the breakpoint bank and returns a registered stop reply to the stub.
module nerv_gdb_runctl
    import nerv_gdb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NBKPT      = 4,
    parameter int RST_CYC    = 4,
    parameter bit RESET_HALT = 1'b1,
    localparam int IW        = idx_width(NBKPT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_vld,
    output logic            cmd_rdy,
    input  logic [1:0]      cmd,
    output logic            stop_vld,
    input  logic            stop_rdy,
    output logic [7:0]      stop_sig,
    output logic            stop_bp,
    output logic [IW-1:0]   stop_idx,
    input  logic            bp_we,
    input  logic [IW-1:0]   bp_idx,
    input  logic            bp_en,
    input  logic [XLEN-1:0] bp_addr,
    input  logic            ret_vld,
    input  logic [XLEN-1:0] ret_pc_nxt,
    output logic            cpu_stall,
    output logic            cpu_rst
);

    localparam int     CW        = idx_width(RST_CYC);
    localparam state_t RST_STATE = RESET_HALT ? ST_HALTED : ST_RUN;

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   cnt_r, cnt_nxt_s;
    cmd_t            cmd_s;
    logic            cmd_rdy_s, cmd_acc_s, stall_s;
    logic            hit_s;
    logic [IW-1:0]   hit_idx_s;
    logic            stop_vld_r, stop_bp_r;
    logic [7:0]      stop_sig_r;
    logic [IW-1:0]   stop_idx_r;
    logic            rep_set_s, rep_bp_s;
    logic [7:0]      rep_sig_s;
    logic [IW-1:0]   rep_idx_s;

    nerv_gdb_bkpt #(
        .XLEN  (XLEN),
        .NBKPT (NBKPT)
    ) u_bkpt (
        .clk        (clk),
        .rst        (rst),
        .bp_we      (bp_we),
        .bp_idx     (bp_idx),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .ret_vld    (ret_vld),
        .ret_pc_nxt (ret_pc_nxt),
        .hit        (hit_s),
        .idx        (hit_idx_s)
    );

    assign cmd_s     = cmd_t'(cmd);
    assign cmd_acc_s = cmd_vld & cmd_rdy_s;

    // Command acceptance: a halted core takes no new command while a reply is pending.
    always_comb begin
        cmd_rdy_s = 1'b0;
        case (state_r)
            ST_RUN:    cmd_rdy_s = 1'b1;
            ST_HALTED: cmd_rdy_s = ~stop_vld_r;
            default:   cmd_rdy_s = 1'b0;
        endcase
    end

    // Next-state, stall and reply-posting decisions.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_s     = 1'b1;
        rep_set_s   = 1'b0;
        rep_sig_s   = SIG_TRAP;
        rep_bp_s    = 1'b0;
        rep_idx_s   = '0;
        case (state_r)
            ST_RUN: begin
                // Stall in the hit cycle itself so the breakpointed instruction never issues.
                stall_s = hit_s;
                if (cmd_acc_s && (cmd_s == CMD_RESET)) begin
                    state_nxt_s = ST_RESET;
                    cnt_nxt_s   = CW'(RST_CYC - 1);
                end else if (hit_s) begin
                    state_nxt_s = ST_HALTED;
                    rep_set_s   = 1'b1;
                    rep_bp_s    = 1'b1;
                    rep_idx_s   = hit_idx_s;
                end else if (cmd_acc_s && (cmd_s == CMD_HALT)) begin
                    state_nxt_s = ST_HALTED;
                    rep_set_s   = 1'b1;
                    rep_sig_s   = SIG_INT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (cmd_acc_s) begin
                    case (cmd_s)
                        CMD_CONT: state_nxt_s = ST_RUN;
                        CMD_STEP: state_nxt_s = ST_STEP;
                        CMD_RESET: begin
                            state_nxt_s = ST_RESET;
                            cnt_nxt_s   = CW'(RST_CYC - 1);
                        end
                        default: begin
                            rep_set_s = 1'b1;
                            rep_sig_s = SIG_INT;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            ST_STEP: begin
                stall_s = ret_vld;
                if (ret_vld) begin
                    state_nxt_s = ST_HALTED;
                    rep_set_s   = 1'b1;
                    rep_bp_s    = hit_s;
                    rep_idx_s   = hit_idx_s;
                end else begin
                    state_nxt_s = ST_STEP;
                end
            end
            ST_RESET: begin
                if (cnt_r == '0) begin
                    state_nxt_s = ST_HALTED;
                    rep_set_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            default: state_nxt_s = ST_HALTED;
        endcase
    end

    // FSM state and reset-hold counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RST_STATE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Stop reply register: posting wins, otherwise the handshake retires it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_vld_r <= RESET_HALT;
            stop_sig_r <= SIG_TRAP;
            stop_bp_r  <= 1'b0;
            stop_idx_r <= '0;
        end else if (rep_set_s) begin
            stop_vld_r <= 1'b1;
            stop_sig_r <= rep_sig_s;
            stop_bp_r  <= rep_bp_s;
            stop_idx_r <= rep_idx_s;
        end else if (stop_vld_r && stop_rdy) begin
            stop_vld_r <= 1'b0;
        end
    end

    assign cmd_rdy   = cmd_rdy_s;
    assign stop_vld  = stop_vld_r;
    assign stop_sig  = stop_sig_r;
    assign stop_bp   = stop_bp_r;
    assign stop_idx  = stop_idx_r;
    assign cpu_stall = stall_s;
    assign cpu_rst   = (state_r == ST_RESET);

endmodule

// File: tb/tb_nerv_gdb_runctl.sv
// Self-checking bench for nerv_gdb_runctl: directed vector table, a reset
// corner sequence, then random traffic against a behavioural model.
module tb_nerv_gdb_runctl;

    localparam int NB      = 4;
    localparam int RST_CYC = 4;
    localparam logic [1:0] C_HALT  = 2'd0;
    localparam logic [1:0] C_CONT  = 2'd1;
    localparam logic [1:0] C_STEP  = 2'd2;
    localparam logic [1:0] C_RESET = 2'd3;

    typedef struct packed {
        logic        cv;
        logic [1:0]  cmd;
        logic        srdy;
        logic        rv;
        logic [31:0] pc;
        logic        we;
        logic [1:0]  bi;
        logic        be;
        logic [31:0] ba;
    } in_t;

    typedef struct packed {
        in_t         stim;
        logic [14:0] exp;
    } vec_t;

    logic        clk, rst;
    logic        cmd_vld, cmd_rdy, stop_vld, stop_rdy, stop_bp;
    logic [1:0]  cmd, stop_idx, bp_idx;
    logic [7:0]  stop_sig;
    logic        bp_we, bp_en, ret_vld, cpu_stall, cpu_rst;
    logic [31:0] bp_addr, ret_pc_nxt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    nerv_gdb_runctl #(.XLEN(32), .NBKPT(NB), .RST_CYC(RST_CYC), .RESET_HALT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd(cmd),
        .stop_vld(stop_vld), .stop_rdy(stop_rdy), .stop_sig(stop_sig), .stop_bp(stop_bp),
        .stop_idx(stop_idx), .bp_we(bp_we), .bp_idx(bp_idx), .bp_en(bp_en), .bp_addr(bp_addr),
        .ret_vld(ret_vld), .ret_pc_nxt(ret_pc_nxt), .cpu_stall(cpu_stall), .cpu_rst(cpu_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: {rdy, stall, cpu_rst, vld, sig[7:0], bp, idx[1:0]}
    function automatic logic [14:0] E(input logic rdy, input logic stall, input logic crst,
                                      input logic vld, input logic [7:0] sig, input logic bp,
                                      input logic [1:0] idx);
        return {rdy, stall, crst, vld, sig, bp, idx};
    endfunction

    // Reply payload is meaningless without vld; the index only with bp.
    function automatic logic [14:0] msk(input logic [14:0] x);
        logic [14:0] y;
        y = x;
        if (!y[11]) y[10:0] = '0;
        else if (!y[2]) y[1:0] = '0;
        return y;
    endfunction

    function automatic in_t mk(input logic cv, input logic [1:0] c, input logic sr,
                               input logic rv, input logic [31:0] pc);
        in_t v;
        v = '0;
        v.cv = cv; v.cmd = c; v.srdy = sr; v.rv = rv; v.pc = pc;
        return v;
    endfunction

    function automatic in_t mkw(input logic [1:0] bi, input logic [31:0] ba);
        in_t v;
        v = '0;
        v.we = 1'b1; v.bi = bi; v.be = 1'b1; v.ba = ba;
        return v;
    endfunction

    function automatic vec_t V(input in_t s, input logic [14:0] e);
        vec_t r;
        r.stim = s;
        r.exp  = e;
        return r;
    endfunction

    // ---------------- behavioural reference model ----------------
    bit          m_halt, m_step, m_vld, m_bp;
    int          m_rleft;
    logic [7:0]  m_sig;
    logic [1:0]  m_idx;
    bit          m_en [NB];
    logic [31:0] m_addr [NB];

    task automatic m_reset();
        m_halt = 1'b1; m_step = 1'b0; m_rleft = 0;
        m_vld = 1'b1; m_sig = 8'd5; m_bp = 1'b0; m_idx = 2'd0;
        for (int k = 0; k < NB; k++) begin
            m_en[k] = 1'b0;
            m_addr[k] = 32'd0;
        end
    endtask

    function automatic void m_hit(input logic [31:0] pc, output bit h, output logic [1:0] ix);
        h = 1'b0;
        ix = 2'd0;
        for (int k = 0; k < NB; k++) begin
            if (!h && m_en[k] && (m_addr[k] / 4 == pc / 4)) begin
                h = 1'b1;
                ix = 2'(k);
            end
        end
    endfunction

    function automatic logic [14:0] m_out(input in_t v);
        bit h, resetting, running;
        logic [1:0] ix;
        logic rdy, stall;
        m_hit(v.pc, h, ix);
        resetting = (m_rleft > 0);
        running = !resetting && !m_halt && !m_step;
        rdy = (resetting || m_step) ? 1'b0 : (m_halt ? !m_vld : 1'b1);
        stall = resetting || m_halt || (m_step && v.rv) || (running && v.rv && h);
        return E(rdy, stall, resetting, m_vld, m_sig, m_bp, m_idx);
    endfunction

    task automatic m_next(input in_t v);
        bit h, acc, post, pbp, clr;
        logic [1:0] ix, pix;
        logic [7:0] psig;
        logic [14:0] o;
        o = m_out(v);
        acc = v.cv && o[14];
        clr = m_vld && v.srdy;
        m_hit(v.pc, h, ix);
        h = h && v.rv;
        post = 1'b0; psig = 8'd5; pbp = 1'b0; pix = 2'd0;
        if (m_rleft > 0) begin
            m_rleft--;
            if (m_rleft == 0) begin m_halt = 1'b1; post = 1'b1; end
        end else if (m_halt) begin
            if (acc) begin
                if (v.cmd == C_HALT) begin post = 1'b1; psig = 8'd2; end
                else if (v.cmd == C_CONT) m_halt = 1'b0;
                else if (v.cmd == C_STEP) begin m_halt = 1'b0; m_step = 1'b1; end
                else begin m_halt = 1'b0; m_rleft = RST_CYC; end
            end
        end else if (m_step) begin
            if (v.rv) begin
                m_step = 1'b0; m_halt = 1'b1;
                post = 1'b1; pbp = h; pix = ix;
            end
        end else begin
            if (acc && v.cmd == C_RESET) m_rleft = RST_CYC;
            else if (h) begin m_halt = 1'b1; post = 1'b1; pbp = 1'b1; pix = ix; end
            else if (acc && v.cmd == C_HALT) begin m_halt = 1'b1; post = 1'b1; psig = 8'd2; end
        end
        if (post) begin
            m_vld = 1'b1; m_sig = psig; m_bp = pbp; m_idx = pix;
        end else if (clr) begin
            m_vld = 1'b0;
        end
        if (v.we) begin
            m_en[v.bi] = v.be;
            m_addr[v.bi] = v.ba;
        end
    endtask

    // ---------------- driving and checking ----------------
    task automatic drive(input in_t v);
        cmd_vld = v.cv; cmd = v.cmd; stop_rdy = v.srdy;
        ret_vld = v.rv; ret_pc_nxt = v.pc;
        bp_we = v.we; bp_idx = v.bi; bp_en = v.be; bp_addr = v.ba;
    endtask

    function automatic logic [14:0] dut_out();
        return {cmd_rdy, cpu_stall, cpu_rst, stop_vld, stop_sig, stop_bp, stop_idx};
    endfunction

    task automatic chk(input string nm, input logic [14:0] a, input logic [14:0] e);
        checks++;
        if (msk(a) !== msk(e)) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, msk(a), msk(e));
        end
    endtask

    // Called at posedge+1: apply inputs, check mid-cycle, advance model and clock.
    task automatic tick(input in_t v, input bit use_tab, input logic [14:0] texp, input string nm);
        drive(v);
        #2;
        chk(nm, dut_out(), use_tab ? texp : m_out(v));
        m_next(v);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] b;
        case ($urandom_range(4))
            0: b = 32'h0000_0100;
            1: b = 32'h0000_0104;
            2: b = 32'h0000_0300;
            3: b = 32'h0000_2000;
            default: b = 32'h0000_0040;
        endcase
        return b | 32'($urandom_range(3));
    endfunction

    vec_t tab[$];
    in_t  idle, srdy, rv;

    initial begin
        idle = mk(1'b0, C_HALT, 1'b0, 1'b0, 32'h0);
        srdy = mk(1'b0, C_HALT, 1'b1, 1'b0, 32'h0);

        tab.push_back(V(idle,                                      E(1'b0,1'b1,1'b0,1'b1,8'd5,1'b0,2'd0)));
        tab.push_back(V(mk(1'b1, C_CONT, 1'b1, 1'b0, 32'h0),       E(1'b0,1'b1,1'b0,1'b1,8'd5,1'b0,2'd0)));
        tab.push_back(V(mkw(2'd0, 32'h100),                        E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(mk(1'b1, C_CONT, 1'b0, 1'b0, 32'h0),       E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(mk(1'b0, C_HALT, 1'b0, 1'b1, 32'h80),      E(1'b1,1'b0,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(mk(1'b0, C_HALT, 1'b0, 1'b1, 32'h102),     E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(idle,                                      E(1'b0,1'b1,1'b0,1'b1,8'd5,1'b1,2'd0)));
        tab.push_back(V(srdy,                                      E(1'b0,1'b1,1'b0,1'b1,8'd5,1'b1,2'd0)));
        tab.push_back(V(mk(1'b1, C_STEP, 1'b0, 1'b0, 32'h0),       E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(idle,                                      E(1'b0,1'b0,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(mk(1'b0, C_HALT, 1'b0, 1'b1, 32'h200),     E(1'b0,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(srdy,                                      E(1'b0,1'b1,1'b0,1'b1,8'd5,1'b0,2'd0)));
        tab.push_back(V(mk(1'b1, C_CONT, 1'b0, 1'b0, 32'h0),       E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(mk(1'b1, C_HALT, 1'b0, 1'b1, 32'h40),      E(1'b1,1'b0,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(srdy,                                      E(1'b0,1'b1,1'b0,1'b1,8'd2,1'b0,2'd0)));
        tab.push_back(V(mk(1'b1, C_HALT, 1'b0, 1'b0, 32'h0),       E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(srdy,                                      E(1'b0,1'b1,1'b0,1'b1,8'd2,1'b0,2'd0)));
        tab.push_back(V(mkw(2'd1, 32'h300),                        E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(mk(1'b1, C_CONT, 1'b0, 1'b0, 32'h0),       E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(mk(1'b1, C_HALT, 1'b0, 1'b1, 32'h300),     E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(srdy,                                      E(1'b0,1'b1,1'b0,1'b1,8'd5,1'b1,2'd1)));
        tab.push_back(V(idle,                                      E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(mkw(2'd2, 32'h300),                        E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(mk(1'b1, C_CONT, 1'b0, 1'b0, 32'h0),       E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(mk(1'b0, C_HALT, 1'b0, 1'b1, 32'h301),     E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(srdy,                                      E(1'b0,1'b1,1'b0,1'b1,8'd5,1'b1,2'd1)));
        tab.push_back(V(mk(1'b1, C_STEP, 1'b0, 1'b0, 32'h0),       E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(mk(1'b0, C_HALT, 1'b0, 1'b1, 32'h100),     E(1'b0,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(srdy,                                      E(1'b0,1'b1,1'b0,1'b1,8'd5,1'b1,2'd0)));
        tab.push_back(V(mk(1'b1, C_RESET, 1'b0, 1'b0, 32'h0),      E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0)));
        for (int k = 0; k < RST_CYC; k++)
            tab.push_back(V(idle,                                  E(1'b0,1'b1,1'b1,1'b0,8'd0,1'b0,2'd0)));
        tab.push_back(V(idle,                                      E(1'b0,1'b1,1'b0,1'b1,8'd5,1'b0,2'd0)));
        tab.push_back(V(srdy,                                      E(1'b0,1'b1,1'b0,1'b1,8'd5,1'b0,2'd0)));

        // Power-on reset and reset-value check
        rst = 1'b0;
        drive(idle);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_values", dut_out(), E(1'b0,1'b1,1'b0,1'b1,8'd5,1'b0,2'd0));
        m_reset();
        rst = 1'b1;

        for (int i = 0; i < tab.size(); i++)
            tick(tab[i].stim, 1'b1, tab[i].exp, $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a step
        tick(mk(1'b1, C_STEP, 1'b0, 1'b0, 32'h0), 1'b1, E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0), "step_cmd");
        tick(idle, 1'b1, E(1'b0,1'b0,1'b0,1'b0,8'd0,1'b0,2'd0), "step_wait");
        rst = 1'b0;
        drive(idle);
        #2;
        chk("rst_mid_step", dut_out(), E(1'b0,1'b1,1'b0,1'b1,8'd5,1'b0,2'd0));
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(srdy, 1'b1, E(1'b0,1'b1,1'b0,1'b1,8'd5,1'b0,2'd0), "post_rst_reply");
        tick(mk(1'b1, C_CONT, 1'b0, 1'b0, 32'h0), 1'b1, E(1'b1,1'b1,1'b0,1'b0,8'd0,1'b0,2'd0), "post_rst_cont");
        tick(mk(1'b0, C_HALT, 1'b0, 1'b1, 32'h100), 1'b1, E(1'b1,1'b0,1'b0,1'b0,8'd0,1'b0,2'd0), "bp_cleared");

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            in_t v;
            v = '0;
            v.cv   = ($urandom_range(3) == 0);
            v.cmd  = 2'($urandom_range(3));
            v.srdy = 1'($urandom_range(1));
            v.rv   = 1'($urandom_range(1));
            v.pc   = pick_pc();
            v.we   = ($urandom_range(15) == 0);
            v.bi   = 2'($urandom_range(3));
            v.be   = ($urandom_range(3) != 0);
            v.ba   = pick_pc();
            tick(v, 1'b0, 15'd0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
